// File: rtl/axi_slave_mem_responder_pkg.sv
// Shared constants, FSM state types and burst helpers for the AXI4 slave memory responder.
package axi_slv_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Reserved burst type or WRAP with a non power-of-two beat count.
  function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  function automatic logic [1:0] resp_of(input logic dec, input logic slv);
    if (dec) return RESP_DECERR;
    if (slv) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_slave_mem_responder_if.sv
// AXI4 write/read channel bundle between a bus master and the slave memory responder.
interface axi_slave_mem_responder_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] WR_ADDR_ID;
  logic [31:0]     WR_ADDR;
  logic [7:0]      WR_ADDR_LEN;
  logic [1:0]      WR_ADDR_BURST;
  logic            WR_ADDR_VALID;
  logic            WR_ADDR_READY;
  logic [31:0]     WR_DATA;
  logic [3:0]      WR_STRB;
  logic            WR_DATA_LAST;
  logic            WR_DATA_VALID;
  logic            WR_DATA_READY;
  logic [ID_W-1:0] WR_BACK_ID;
  logic [1:0]      WR_BACK_RESP;
  logic            WR_BACK_VALID;
  logic            WR_BACK_READY;
  logic [ID_W-1:0] RD_ADDR_ID;
  logic [31:0]     RD_ADDR;
  logic [7:0]      RD_ADDR_LEN;
  logic [1:0]      RD_ADDR_BURST;
  logic            RD_ADDR_VALID;
  logic            RD_ADDR_READY;
  logic [ID_W-1:0] RD_BACK_ID;
  logic [31:0]     RD_DATA;
  logic [1:0]      RD_DATA_RESP;
  logic            RD_DATA_LAST;
  logic            RD_DATA_VALID;
  logic            RD_DATA_READY;

  modport slave (
    input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    input  WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID, WR_BACK_READY,
    input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID, RD_DATA_READY,
    output WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    output RD_ADDR_READY, RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID
  );

  modport master (
    output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    output WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID, WR_BACK_READY,
    output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID, RD_DATA_READY,
    input  WR_ADDR_READY, WR_DATA_READY, WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    input  RD_ADDR_READY, RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID
  );
endinterface

// File: rtl/axi_slave_mem_responder_addr_gen.sv
// Combinational next word address for FIXED / INCR / WRAP bursts; illegal bursts step as INCR.
module axi_burst_addr_gen
  import axi_slv_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic [MEM_AW-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [MEM_AW-1:0] next
);

  logic [MEM_AW-1:0] incr;
  logic [MEM_AW-1:0] mask;

  assign incr = addr + MEM_AW'(1);
  assign mask = MEM_AW'(len);

  // NOTE: every path starts from a default so no latch is inferred.
  always_comb begin
    next = incr;
    case (burst)
      BURST_FIXED: next = addr;
      BURST_WRAP:  if (wrap_len_ok(len)) next = (addr & ~mask) | (incr & mask);
      default:     next = incr;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave responder backed by a local 32-bit word memory; independent write and read FSMs.
// Optional out-of-range decode (DECERR) is enabled with the macro AXI_SLV_DECERR_EN.
module axi_slave_mem_responder
  import axi_slv_pkg::*;
#(
  parameter int          ID_W      = 4,
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic                       CLK,
  input logic                       RST,
  axi_slave_mem_responder_if.slave  bus
);

  logic [31:0] mem [2**MEM_AW];

  logic live;
  logic aw_oor, ar_oor, unused_addr_bits;
  logic aw_hs, w_hs, ar_hs;

  w_state_e          w_state, w_next;
  logic [ID_W-1:0]   w_id;
  logic [MEM_AW-1:0] w_addr, w_addr_nx;
  logic [7:0]        w_len;
  logic [1:0]        w_burst;
  logic [8:0]        w_cnt;
  logic              w_err, w_bad, w_dec;

  r_state_e          r_state, r_next;
  logic [ID_W-1:0]   r_id;
  logic [MEM_AW-1:0] r_addr, r_addr_nx;
  logic [7:0]        r_len, r_cnt;
  logic [1:0]        r_burst;
  logic              r_bad, r_dec, r_last;
  logic [31:0]       r_data;

`ifdef AXI_SLV_DECERR_EN
  assign aw_oor = bus.WR_ADDR[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2];
  assign ar_oor = bus.RD_ADDR[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2];
  assign unused_addr_bits = ^{bus.WR_ADDR[1:0], bus.RD_ADDR[1:0]};
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
  assign unused_addr_bits = ^{bus.WR_ADDR[31:MEM_AW+2], bus.WR_ADDR[1:0],
                              bus.RD_ADDR[31:MEM_AW+2], bus.RD_ADDR[1:0], BASE_ADDR};
`endif

  axi_burst_addr_gen #(.MEM_AW(MEM_AW)) u_w_addr_gen (
    .addr(w_addr), .len(w_len), .burst(w_burst), .next(w_addr_nx));
  axi_burst_addr_gen #(.MEM_AW(MEM_AW)) u_r_addr_gen (
    .addr(r_addr), .len(r_len), .burst(r_burst), .next(r_addr_nx));

  // Holds address READY low for the cycle after reset so READY is 0 while RST is applied.
  always_ff @(posedge CLK) begin
    if (RST) live <= 1'b0;
    else     live <= 1'b1;
  end

  assign aw_hs  = bus.WR_ADDR_VALID & bus.WR_ADDR_READY;
  assign w_hs   = bus.WR_DATA_VALID & bus.WR_DATA_READY;
  assign ar_hs  = bus.RD_ADDR_VALID & bus.RD_ADDR_READY;
  assign r_last = r_cnt == r_len;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next            = w_state;
    bus.WR_ADDR_READY = 1'b0;
    bus.WR_DATA_READY = 1'b0;
    bus.WR_BACK_VALID = 1'b0;
    case (w_state)
      W_IDLE: begin
        bus.WR_ADDR_READY = live;
        if (bus.WR_ADDR_VALID && live) w_next = W_DATA;
      end
      W_DATA: begin
        bus.WR_DATA_READY = 1'b1;
        if (bus.WR_DATA_VALID && bus.WR_DATA_LAST) w_next = W_RESP;
      end
      W_RESP: begin
        bus.WR_BACK_VALID = 1'b1;
        if (bus.WR_BACK_READY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      w_id <= '0; w_addr <= '0; w_len <= '0; w_burst <= '0;
      w_cnt <= '0; w_err <= 1'b0; w_bad <= 1'b0; w_dec <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= bus.WR_ADDR_ID;
      w_addr  <= bus.WR_ADDR[MEM_AW+1:2];
      w_len   <= bus.WR_ADDR_LEN;
      w_burst <= bus.WR_ADDR_BURST;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_bad   <= burst_illegal(bus.WR_ADDR_BURST, bus.WR_ADDR_LEN);
      w_dec   <= aw_oor;
    end else if (w_hs) begin
      if (bus.WR_DATA_LAST != (w_cnt == {1'b0, w_len})) w_err <= 1'b1;
      w_addr <= w_addr_nx;
      if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
    end
  end

  // NOTE: memory contents are deliberately not reset; only control and output registers are.
  always_ff @(posedge CLK) begin
    if (!RST && w_hs && (w_cnt <= {1'b0, w_len}) && !w_dec) begin
      for (int b = 0; b < 4; b++)
        if (bus.WR_STRB[b]) mem[w_addr][8*b +: 8] <= bus.WR_DATA[8*b +: 8];
    end
  end

  assign bus.WR_BACK_ID   = w_id;
  assign bus.WR_BACK_RESP = resp_of(w_dec, w_err | w_bad);

  always_comb begin
    r_next            = r_state;
    bus.RD_ADDR_READY = 1'b0;
    bus.RD_DATA_VALID = 1'b0;
    bus.RD_DATA_LAST  = 1'b0;
    case (r_state)
      R_IDLE: begin
        bus.RD_ADDR_READY = live;
        if (bus.RD_ADDR_VALID && live) r_next = R_FETCH;
      end
      R_FETCH: r_next = R_DATA;
      R_DATA: begin
        bus.RD_DATA_VALID = 1'b1;
        bus.RD_DATA_LAST  = r_last;
        if (bus.RD_DATA_READY) r_next = r_last ? R_IDLE : R_FETCH;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_burst <= '0;
      r_cnt <= '0; r_bad <= 1'b0; r_dec <= 1'b0;
    end else if (ar_hs) begin
      r_id    <= bus.RD_ADDR_ID;
      r_addr  <= bus.RD_ADDR[MEM_AW+1:2];
      r_len   <= bus.RD_ADDR_LEN;
      r_burst <= bus.RD_ADDR_BURST;
      r_cnt   <= '0;
      r_bad   <= burst_illegal(bus.RD_ADDR_BURST, bus.RD_ADDR_LEN);
      r_dec   <= ar_oor;
    end else if ((r_state == R_DATA) && bus.RD_DATA_READY && !r_last) begin
      r_addr <= r_addr_nx;
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  // Sampling the array on the same edge as a write returns the pre-write word (read-first).
  always_ff @(posedge CLK) begin
    if (RST)                     r_data <= '0;
    else if (r_state == R_FETCH) r_data <= r_dec ? 32'h0 : mem[r_addr];
  end

  assign bus.RD_BACK_ID   = r_id;
  assign bus.RD_DATA      = r_data;
  assign bus.RD_DATA_RESP = resp_of(r_dec, r_bad);

endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed self-checking bench for axi_slave_mem_responder (default build or AXI_SLV_DECERR_EN).
module tb_axi_slave_mem_responder;
  import axi_slv_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  axi_slave_mem_responder_if #(.ID_W(4)) bus ();

  axi_slave_mem_responder #(.ID_W(4), .MEM_AW(10), .BASE_ADDR(32'h0)) dut (
    .CLK(CLK), .RST(RST), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd_d  [16];
  logic [1:0]  rd_rs [16];
  logic        rd_l  [16];
  logic [3:0]  rd_id [16];
  int          rd_lat[16];

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0; logic hs = 1'b0;
    bus.WR_ADDR_ID = id; bus.WR_ADDR = addr; bus.WR_ADDR_LEN = len;
    bus.WR_ADDR_BURST = burst; bus.WR_ADDR_VALID = 1'b1;
    while (!hs && n < 50) begin
      @(negedge CLK); hs = bus.WR_ADDR_READY;
      @(posedge CLK); #1; n++;
    end
    bus.WR_ADDR_VALID = 1'b0;
    if (!hs) begin checks++; failures++; $display("FAIL aw_timeout got no ready in %0d cycles", n); end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic last);
    int n = 0; logic hs = 1'b0;
    bus.WR_DATA = d; bus.WR_STRB = strb; bus.WR_DATA_LAST = last; bus.WR_DATA_VALID = 1'b1;
    while (!hs && n < 50) begin
      @(negedge CLK); hs = bus.WR_DATA_READY;
      @(posedge CLK); #1; n++;
    end
    bus.WR_DATA_VALID = 1'b0; bus.WR_DATA_LAST = 1'b0;
    if (!hs) begin checks++; failures++; $display("FAIL w_timeout got no ready in %0d cycles", n); end
  endtask

  task automatic recv_b(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    bus.WR_BACK_READY = 1'b1;
    do begin @(negedge CLK); n++; end while (!bus.WR_BACK_VALID && n < 50);
    resp = bus.WR_BACK_RESP; id = bus.WR_BACK_ID;
    if (!bus.WR_BACK_VALID) begin checks++; failures++; $display("FAIL b_timeout no valid in %0d cycles", n); end
    @(posedge CLK); #1;
    bus.WR_BACK_READY = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, input logic [31:0] d0,
                             input logic [31:0] step, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] bid);
    send_aw(id, addr, len, burst);
    for (int i = 0; i < nbeats; i++) send_w(d0 + step * 32'(i), strb, i == nbeats - 1);
    recv_b(resp, bid);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0; logic hs = 1'b0;
    bus.RD_ADDR_ID = id; bus.RD_ADDR = addr; bus.RD_ADDR_LEN = len;
    bus.RD_ADDR_BURST = burst; bus.RD_ADDR_VALID = 1'b1;
    while (!hs && n < 50) begin
      @(negedge CLK); hs = bus.RD_ADDR_READY;
      @(posedge CLK); #1; n++;
    end
    bus.RD_ADDR_VALID = 1'b0;
    if (!hs) begin checks++; failures++; $display("FAIL ar_timeout got no ready in %0d cycles", n); end
  endtask

  task automatic recv_beat(input int i);
    int n = 0;
    bus.RD_DATA_READY = 1'b1;
    do begin @(negedge CLK); n++; end while (!bus.RD_DATA_VALID && n < 50);
    rd_d[i] = bus.RD_DATA; rd_rs[i] = bus.RD_DATA_RESP; rd_l[i] = bus.RD_DATA_LAST;
    rd_id[i] = bus.RD_BACK_ID; rd_lat[i] = n;
    if (!bus.RD_DATA_VALID) begin checks++; failures++; $display("FAIL r_timeout no valid in %0d cycles", n); end
    @(posedge CLK); #1;
    bus.RD_DATA_READY = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
    send_ar(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) recv_beat(i);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.WR_ADDR_READY !== 1'b0) begin failures++; $display("FAIL rst_awready got %b want 0", bus.WR_ADDR_READY); end
    checks++; if (bus.RD_ADDR_READY !== 1'b0) begin failures++; $display("FAIL rst_arready got %b want 0", bus.RD_ADDR_READY); end
    checks++; if (bus.WR_DATA_READY !== 1'b0) begin failures++; $display("FAIL rst_wready got %b want 0", bus.WR_DATA_READY); end
    checks++; if (bus.WR_BACK_VALID !== 1'b0) begin failures++; $display("FAIL rst_bvalid got %b want 0", bus.WR_BACK_VALID); end
    checks++; if (bus.RD_DATA_VALID !== 1'b0) begin failures++; $display("FAIL rst_rvalid got %b want 0", bus.RD_DATA_VALID); end
    checks++; if (bus.RD_DATA_LAST !== 1'b0) begin failures++; $display("FAIL rst_rlast got %b want 0", bus.RD_DATA_LAST); end
    checks++; if (bus.RD_DATA !== 32'h0) begin failures++; $display("FAIL rst_rdata got %h want 0", bus.RD_DATA); end
    checks++; if ({bus.WR_BACK_RESP, bus.RD_DATA_RESP, bus.WR_BACK_ID, bus.RD_BACK_ID} !== 12'h0) begin
      failures++; $display("FAIL rst_resp_id got %h want 000", {bus.WR_BACK_RESP, bus.RD_DATA_RESP, bus.WR_BACK_ID, bus.RD_BACK_ID}); end
    @(posedge CLK); #1; RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if ({bus.WR_ADDR_READY, bus.RD_ADDR_READY} !== 2'b11) begin
      failures++; $display("FAIL idle_ready got %b want 11", {bus.WR_ADDR_READY, bus.RD_ADDR_READY}); end
    @(posedge CLK); #1;
  endtask

  task automatic test_incr();
    logic [1:0] resp; logic [3:0] bid;
    write_burst(4'd5, 32'h10, 8'd3, BURST_INCR, 4, 32'hA0, 32'h1, 4'hF, resp, bid);
    checks++; if (resp !== RESP_OKAY) begin failures++; $display("FAIL incr_bresp got %b want 00", resp); end
    checks++; if (bid !== 4'd5) begin failures++; $display("FAIL incr_bid got %0d want 5", bid); end
    read_burst(4'd9, 32'h10, 8'd3, BURST_INCR);
    checks++; if (rd_lat[0] !== 2) begin failures++; $display("FAIL incr_latency got %0d want 2", rd_lat[0]); end
    checks++; if (rd_id[0] !== 4'd9) begin failures++; $display("FAIL incr_rid got %0d want 9", rd_id[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rd_d[i], rd_rs[i], rd_l[i]} !== {32'hA0 + 32'(i), RESP_OKAY, i == 3}) begin
        failures++; $display("FAIL incr_beat%0d got data=%h resp=%b last=%b want data=%h resp=00 last=%b",
                             i, rd_d[i], rd_rs[i], rd_l[i], 32'hA0 + 32'(i), i == 3); end
    end
  endtask

  task automatic test_bursts();
    logic [1:0] resp; logic [3:0] bid;
    logic [31:0] exp_wrap [4];
    exp_wrap[0] = 32'hE0; exp_wrap[1] = 32'hF0; exp_wrap[2] = 32'hC0; exp_wrap[3] = 32'hD0;
    write_burst(4'd1, 32'h30, 8'd3, BURST_INCR, 4, 32'hC0, 32'h10, 4'hF, resp, bid);
    checks++; if (resp !== RESP_OKAY) begin failures++; $display("FAIL wrapfill_bresp got %b want 00", resp); end
    read_burst(4'd2, 32'h38, 8'd3, BURST_WRAP);
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rd_d[i], rd_rs[i]} !== {exp_wrap[i], RESP_OKAY}) begin
        failures++; $display("FAIL wrap_beat%0d got data=%h resp=%b want data=%h resp=00", i, rd_d[i], rd_rs[i], exp_wrap[i]); end
    end
    read_burst(4'd3, 32'h10, 8'd2, BURST_WRAP);
    for (int i = 0; i < 3; i++) begin
      checks++; if ({rd_d[i], rd_rs[i]} !== {32'hA0 + 32'(i), RESP_SLVERR}) begin
        failures++; $display("FAIL badwrap_beat%0d got data=%h resp=%b want data=%h resp=10", i, rd_d[i], rd_rs[i], 32'hA0 + 32'(i)); end
    end
    read_burst(4'd4, 32'h14, 8'd1, BURST_FIXED);
    for (int i = 0; i < 2; i++) begin
      checks++; if ({rd_d[i], rd_rs[i], rd_l[i]} !== {32'hA1, RESP_OKAY, i == 1}) begin
        failures++; $display("FAIL fixed_beat%0d got data=%h resp=%b last=%b want data=000000a1 resp=00", i, rd_d[i], rd_rs[i], rd_l[i]); end
    end
  endtask

  task automatic test_write_errors();
    logic [1:0] resp; logic [3:0] bid;
    write_burst(4'd3, 32'h0, 8'd1, BURST_INCR, 2, 32'h0, 32'h0, 4'hF, resp, bid);
    checks++; if (resp !== RESP_OKAY) begin failures++; $display("FAIL clear_bresp got %b want 00", resp); end
    write_burst(4'd3, 32'h0, 8'd2, BURST_INCR, 2, 32'hFFFF_FFFF, 32'h0, 4'b0101, resp, bid);
    checks++; if (resp !== RESP_SLVERR) begin failures++; $display("FAIL early_last_bresp got %b want 10", resp); end
    read_burst(4'd3, 32'h0, 8'd1, BURST_INCR);
    for (int i = 0; i < 2; i++) begin
      checks++; if (rd_d[i] !== 32'h00FF_00FF) begin failures++; $display("FAIL strb_word%0d got %h want 00ff00ff", i, rd_d[i]); end
    end
    write_burst(4'd4, 32'h84, 8'd0, BURST_INCR, 1, 32'h3333_3333, 32'h0, 4'hF, resp, bid);
    write_burst(4'd4, 32'h80, 8'd0, BURST_INCR, 2, 32'h1111_1111, 32'h1111_1111, 4'hF, resp, bid);
    checks++; if (resp !== RESP_SLVERR) begin failures++; $display("FAIL late_last_bresp got %b want 10", resp); end
    read_burst(4'd4, 32'h80, 8'd1, BURST_INCR);
    checks++; if ({rd_d[0], rd_d[1]} !== {32'h1111_1111, 32'h3333_3333}) begin
      failures++; $display("FAIL dropped_beat got %h %h want 11111111 33333333", rd_d[0], rd_d[1]); end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [3:0] bid; int n;
    send_ar(4'd7, 32'h10, 8'd3, BURST_INCR);
    recv_beat(0);
    n = 0;
    do begin @(negedge CLK); n++; end while (!bus.RD_DATA_VALID && n < 50);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); @(negedge CLK);
      checks++; if ({bus.RD_DATA_VALID, bus.RD_DATA, bus.RD_DATA_LAST} !== {1'b1, 32'hA1, 1'b0}) begin
        failures++; $display("FAIL rstall_cyc%0d got valid=%b data=%h last=%b want 1 a1 0",
                             k, bus.RD_DATA_VALID, bus.RD_DATA, bus.RD_DATA_LAST); end
    end
    @(posedge CLK); #1;
    for (int i = 1; i < 4; i++) recv_beat(i);
    checks++; if ({rd_d[1], rd_d[2], rd_d[3], rd_l[3]} !== {32'hA1, 32'hA2, 32'hA3, 1'b1}) begin
      failures++; $display("FAIL rstall_tail got %h %h %h last=%b want a1 a2 a3 1", rd_d[1], rd_d[2], rd_d[3], rd_l[3]); end

    send_aw(4'd6, 32'h100, 8'd0, BURST_INCR);
    send_w(32'h77, 4'hF, 1'b1);
    n = 0;
    do begin @(negedge CLK); n++; end while (!bus.WR_BACK_VALID && n < 50);
    for (int k = 0; k < 3; k++) begin
      checks++; if ({bus.WR_BACK_VALID, bus.WR_ADDR_READY} !== 2'b10) begin
        failures++; $display("FAIL bstall_cyc%0d got bvalid=%b awready=%b want 1 0", k, bus.WR_BACK_VALID, bus.WR_ADDR_READY); end
      @(posedge CLK); @(negedge CLK);
    end
    @(posedge CLK); #1;
    recv_b(resp, bid);
    checks++; if ({resp, bid} !== {RESP_OKAY, 4'd6}) begin failures++; $display("FAIL bstall_resp got %b id %0d want 00 id 6", resp, bid); end
  endtask

  task automatic test_alias();
    logic [1:0] resp; logic [3:0] bid;
`ifdef AXI_SLV_DECERR_EN
    logic [1:0]  exp_resp = RESP_DECERR;
    logic [31:0] exp_hi   = 32'h0;
    logic [31:0] exp_lo   = 32'h00FF_00FF;
`else
    logic [1:0]  exp_resp = RESP_OKAY;
    logic [31:0] exp_hi   = 32'h5A5A_5A5A;
    logic [31:0] exp_lo   = 32'h5A5A_5A5A;
`endif
    write_burst(4'd2, 32'h1000, 8'd0, BURST_INCR, 1, 32'h5A5A_5A5A, 32'h0, 4'hF, resp, bid);
    checks++; if (resp !== exp_resp) begin failures++; $display("FAIL oor_bresp got %b want %b", resp, exp_resp); end
    read_burst(4'd2, 32'h1000, 8'd0, BURST_INCR);
    checks++; if ({rd_d[0], rd_rs[0], rd_l[0]} !== {exp_hi, exp_resp, 1'b1}) begin
      failures++; $display("FAIL oor_read got data=%h resp=%b last=%b want %h %b 1", rd_d[0], rd_rs[0], rd_l[0], exp_hi, exp_resp); end
    read_burst(4'd2, 32'h0, 8'd0, BURST_INCR);
    checks++; if ({rd_d[0], rd_rs[0]} !== {exp_lo, RESP_OKAY}) begin
      failures++; $display("FAIL word0_after_oor got data=%h resp=%b want %h 00", rd_d[0], rd_rs[0], exp_lo); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send_ar(4'd3, 32'h10, 8'd7, BURST_INCR);
    recv_beat(0);
    do begin @(negedge CLK); n++; end while (!bus.RD_DATA_VALID && n < 50);
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    checks++; if ({bus.RD_DATA_VALID, bus.RD_ADDR_READY, bus.RD_DATA_LAST} !== 3'b000) begin
      failures++; $display("FAIL midrst got rvalid=%b arready=%b rlast=%b want 000",
                           bus.RD_DATA_VALID, bus.RD_ADDR_READY, bus.RD_DATA_LAST); end
    @(posedge CLK); #1; RST = 1'b0;
    read_burst(4'd8, 32'h10, 8'd0, BURST_INCR);
    checks++; if ({rd_d[0], rd_rs[0], rd_l[0], rd_id[0]} !== {32'hA0, RESP_OKAY, 1'b1, 4'd8}) begin
      failures++; $display("FAIL post_rst_read got data=%h resp=%b last=%b id=%0d want a0 00 1 8",
                           rd_d[0], rd_rs[0], rd_l[0], rd_id[0]); end
  endtask

  initial begin
    bus.WR_ADDR_ID = '0; bus.WR_ADDR = '0; bus.WR_ADDR_LEN = '0; bus.WR_ADDR_BURST = '0;
    bus.WR_ADDR_VALID = 1'b0; bus.WR_DATA = '0; bus.WR_STRB = '0; bus.WR_DATA_LAST = 1'b0;
    bus.WR_DATA_VALID = 1'b0; bus.WR_BACK_READY = 1'b0;
    bus.RD_ADDR_ID = '0; bus.RD_ADDR = '0; bus.RD_ADDR_LEN = '0; bus.RD_ADDR_BURST = '0;
    bus.RD_ADDR_VALID = 1'b0; bus.RD_DATA_READY = 1'b0;
    test_reset();
    test_incr();
    test_bursts();
    test_write_errors();
    test_backpressure();
    test_alias();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
